io_port_controller: RTL and testbench

- Device-side end of the processor's IN/OUT port and interrupt line.
- Output path: captures each word the processor writes to its Out port into a FIFO, then drains it to an external device over a valid/ready handshake.
- Input path: accepts one word from an external device over valid/ready, holds it stable on the processor's In port, and raises a one-cycle Int request until the processor reads it.
- Sits at the top level beside the processor core; no pipeline-stage coupling.

---
 rtl/io_pkg.sv | 15 +
 rtl/io_sync_fifo.sv | 69 ++++++
 rtl/io_port_controller.sv | 125 ++++++++++++
 tb/tb_io_port_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the processor IN/OUT port controller:
// input FSM state encoding, interrupt retry timeout and default word width.
package io_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int RETRY_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INT_REQ = 2'd1,
        WAIT_RD = 2'd2,
        GAP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head output.
// The head word stays in storage until it is handshaken out, so it occupies
// a slot while the consumer stalls. A write into a full FIFO is accepted only
// when a read frees a slot in the same cycle; otherwise it is dropped and
// reported on the overflow strobe.
module io_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              full,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       rptr_nxt;
    logic              push;
    logic              pop;

    assign pop      = rd_valid && rd_ready;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push     = wr_en && (!full || pop);
    assign overflow = wr_en && full && !pop;
    assign rptr_nxt = rptr + {{AW{1'b0}}, pop};

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update on accepted writes and handshaken reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
            end
            rptr <= rptr_nxt;
        end
    end

    // Registered head: presents the entry at the post-read pointer, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (wptr != rptr_nxt);
            if (wptr != rptr_nxt) begin
                rd_data <= mem[rptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// Device-side end of the processor IN/OUT ports and interrupt line.
// Output path: processor OUT writes are buffered in io_sync_fifo and drained
// to the device over valid/ready. Input path: one device word is captured,
// held on cpu_in and announced with a one-cycle cpu_int pulse.
// Optional feature macro IO_INT_RETRY_EN: re-pulses cpu_int when the
// processor has not read the word within RETRY_TIMEOUT cycles.
module io_port_controller
    import io_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OFIFO_DEPTH = 4,
    parameter int INT_GAP     = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_out_wr,
    output logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_in_rd,
    output logic              cpu_int,
    output logic [DATA_W-1:0] dev_tx_data,
    output logic              dev_tx_valid,
    input  logic              dev_tx_ready,
    input  logic [DATA_W-1:0] dev_rx_data,
    input  logic              dev_rx_valid,
    output logic              dev_rx_ready,
    output logic              ofifo_full,
    output logic              ovf_sticky
);

    localparam int GW = (INT_GAP > 1) ? $clog2(INT_GAP) : 1;

    logic      fifo_ovf;
    rx_state_t state;
    logic [GW-1:0] gap_cnt;
`ifdef IO_INT_RETRY_EN
    logic [15:0] wait_cnt;
`endif

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OFIFO_DEPTH)
    ) u_ofifo (
        .clk      (Clk),
        .rst_n    (Rst),
        .wr_data  (cpu_out),
        .wr_en    (cpu_out_wr),
        .rd_data  (dev_tx_data),
        .rd_valid (dev_tx_valid),
        .rd_ready (dev_tx_ready),
        .full     (ofifo_full),
        .overflow (fifo_ovf)
    );

    // Remember any dropped OUT write until the next reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ovf_sticky <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

    // Input FSM: capture a device word, pulse cpu_int, wait for the IN read, then enforce the gap.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            cpu_in       <= '0;
            cpu_int      <= 1'b0;
            dev_rx_ready <= 1'b1;
            gap_cnt      <= '0;
`ifdef IO_INT_RETRY_EN
            wait_cnt     <= '0;
`endif
        end else begin
            cpu_int <= 1'b0;
            case (state)
                IDLE: begin
                    if (dev_rx_valid) begin
                        cpu_in       <= dev_rx_data;
                        cpu_int      <= 1'b1;
                        dev_rx_ready <= 1'b0;
                        state        <= INT_REQ;
                    end
                end
                INT_REQ: begin
                    // A read coinciding with the pulse itself is deliberately ignored.
                    state <= WAIT_RD;
`ifdef IO_INT_RETRY_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT_RD: begin
                    if (cpu_in_rd) begin
                        if (INT_GAP == 0) begin
                            dev_rx_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
`ifdef IO_INT_RETRY_EN
                    else if (wait_cnt == 16'(RETRY_TIMEOUT - 1)) begin
                        cpu_int <= 1'b1;
                        state   <= INT_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GW'(INT_GAP - 1)) begin
                        dev_rx_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// Scoreboard bench for io_port_controller: directed scenarios followed by
// randomized traffic on both paths, checked against a queue-based model.
module tb_io_port_controller;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [DW-1:0] cpu_out = '0;
    logic          cpu_out_wr = 1'b0;
    logic [DW-1:0] cpu_in;
    logic          cpu_in_rd = 1'b0;
    logic          cpu_int;
    logic [DW-1:0] dev_tx_data;
    logic          dev_tx_valid;
    logic          dev_tx_ready = 1'b0;
    logic [DW-1:0] dev_rx_data = '0;
    logic          dev_rx_valid = 1'b0;
    logic          dev_rx_ready;
    logic          ofifo_full;
    logic          ovf_sticky;

    io_port_controller #(.DATA_W(DW), .OFIFO_DEPTH(DEPTH), .INT_GAP(GAP)) dut (
        .Clk(Clk), .Rst(Rst),
        .cpu_out(cpu_out), .cpu_out_wr(cpu_out_wr),
        .cpu_in(cpu_in), .cpu_in_rd(cpu_in_rd), .cpu_int(cpu_int),
        .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready),
        .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
        .ofifo_full(ofifo_full), .ovf_sticky(ovf_sticky)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state
    typedef struct { logic [DW-1:0] d; int unsigned c; } int_t;
    int unsigned   cyc = 0;
    logic [DW-1:0] tx_q[$];
    int            occ_m = 0;
    bit            ovf_m = 0;
    int_t          int_q[$];
    bit            rx_busy = 0;
    bit            rd_done = 0;
    int unsigned   acc_cyc = 0;
    int unsigned   rd_cyc = 0;
    logic [DW-1:0] last_in = '0;
    bit            mon_int_en = 1;
    int            pulse_cnt = 0;
    int unsigned   pulse_hist[$];

    // Model: FIFO occupancy/overflow and input-word life cycle, from the port-level rules.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tx_q.delete();
            int_q.delete();
            occ_m   = 0;
            ovf_m   = 0;
            rx_busy = 0;
            rd_done = 0;
            last_in = '0;
        end else begin
            bit pop;
            cyc++;
            pop = dev_tx_valid && dev_tx_ready;
            if (cpu_out_wr) begin
                if (occ_m < DEPTH || pop) begin
                    tx_q.push_back(cpu_out);
                    occ_m++;
                end else begin
                    ovf_m = 1;
                end
            end
            if (pop && occ_m > 0) occ_m--;
            if (rx_busy && !rd_done && cpu_in_rd && cyc >= acc_cyc + 2) begin
                rd_done = 1;
                rd_cyc  = cyc;
            end else if (rx_busy && rd_done && cyc == rd_cyc + GAP) begin
                rx_busy = 0;
            end
            if (dev_rx_valid && dev_rx_ready) begin
                rx_busy = 1;
                rd_done = 0;
                acc_cyc = cyc;
                last_in = dev_rx_data;
                int_q.push_back('{dev_rx_data, cyc});
            end
        end
    end

    // Monitor: every handshaken word must be the next expected one.
    always @(posedge Clk) begin
        if (Rst && dev_tx_valid && dev_tx_ready) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_spurious: got word %0h expected none", dev_tx_data);
            end else begin
                chk("tx_data", dev_tx_data, tx_q.pop_front());
            end
        end
    end

    // Monitor: status flags, hold-under-stall, cpu_in and interrupt pulses.
    bit            prev_stall = 0;
    bit            prev_int = 0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge Clk) begin
        if (!Rst) begin
            prev_stall = 0;
            prev_int   = 0;
        end else begin
            int_t f;
            chk("ofifo_full", ofifo_full, occ_m == DEPTH);
            chk("ovf_sticky", ovf_sticky, ovf_m);
            chk("dev_rx_ready", dev_rx_ready, !rx_busy);
            chk("cpu_in", cpu_in, last_in);
            if (prev_stall) begin
                chk("tx_hold_valid", dev_tx_valid, 1);
                chk("tx_hold_data", dev_tx_data, prev_data);
            end
            if (cpu_int) begin
                chk("int_width", prev_int, 0);
                pulse_cnt++;
                pulse_hist.push_back(cyc);
                if (int_q.size() != 0) begin
                    f = int_q.pop_front();
                    chk("int_data", cpu_in, f.d);
                    chk("int_time", cyc, f.c);
                end else if (mon_int_en) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL int_spurious: got cpu_int=1 expected 0 at cycle %0d", cyc);
                end
            end else if (int_q.size() != 0 && int_q[0].c < cyc) begin
                f = int_q.pop_front();
                chk("int_missing", cpu_int, 1);
            end
            prev_stall = dev_tx_valid && !dev_tx_ready;
            prev_data  = dev_tx_data;
            prev_int   = cpu_int;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input string nm);
        dev_tx_ready = 1'b1;
        for (int i = 0; i < 60 && (tx_q.size() != 0 || dev_tx_valid); i++) tick();
        chk(nm, tx_q.size(), 0);
    endtask

    task automatic finish_read(input string nm);
        for (int i = 0; i < 200 && (rx_busy || !dev_rx_ready); i++) begin
            cpu_in_rd = 1'b1;
            tick();
        end
        cpu_in_rd = 1'b0;
        tick();
        chk(nm, dev_rx_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        tick();
        chk("rst_tx_valid", dev_tx_valid, 0);
        chk("rst_rx_ready", dev_rx_ready, 1);
        chk("rst_cpu_int", cpu_int, 0);

        // Output stream with first-word latency
        dev_tx_ready = 1'b1;
        cpu_out_wr = 1'b1; cpu_out = 16'h1111;
        tick();
        cpu_out = 16'h2222;
        chk("lat_edge_n", dev_tx_valid, 0);
        tick();
        cpu_out = 16'h3333;
        chk("lat_edge_n1_valid", dev_tx_valid, 1);
        chk("lat_edge_n1_data", dev_tx_data, 16'h1111);
        tick();
        cpu_out_wr = 1'b0;
        drain("stream_drain");

        // Backpressure and overflow
        dev_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_out_wr = 1'b1; cpu_out = 16'hA000 + 16'(i);
            tick();
            if (i == 3) chk("full_after4", ofifo_full, 1);
        end
        cpu_out_wr = 1'b0;
        chk("ovf_after5", ovf_sticky, 1);
        repeat (3) tick();
        drain("bp_drain");

        // Reset in the middle of traffic, during an interrupt pulse
        dev_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_out_wr = 1'b1; cpu_out = 16'hC000 + 16'(i);
            tick();
        end
        cpu_out_wr = 1'b0;
        dev_rx_valid = 1'b1; dev_rx_data = 16'h0055;
        tick();
        dev_rx_valid = 1'b0;
        chk("pre_rst_int", cpu_int, 1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_cpu_in", cpu_in, 0);
        chk("arst_cpu_int", cpu_int, 0);
        chk("arst_tx_valid", dev_tx_valid, 0);
        chk("arst_tx_data", dev_tx_data, 0);
        chk("arst_rx_ready", dev_rx_ready, 1);
        chk("arst_full", ofifo_full, 0);
        chk("arst_ovf", ovf_sticky, 0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        tick();
        chk("post_rst_rx_ready", dev_rx_ready, 1);
        chk("post_rst_tx_valid", dev_tx_valid, 0);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 4; i++) begin
            cpu_out_wr = 1'b1; cpu_out = 16'hB000 + 16'(i);
            tick();
        end
        cpu_out_wr = 1'b0;
        tick();
        chk("simul_full_before", ofifo_full, 1);
        cpu_out_wr = 1'b1; cpu_out = 16'hBEEF; dev_tx_ready = 1'b1;
        tick();
        cpu_out_wr = 1'b0; dev_tx_ready = 1'b0;
        chk("simul_full_after", ofifo_full, 1);
        chk("simul_no_ovf", ovf_sticky, 0);
        drain("simul_drain");

        // Input interrupt, ignored read in the pulse cycle, gap, queued second word
        dev_rx_valid = 1'b1; dev_rx_data = 16'h00C3;
        tick();
        chk("rx_cpu_in", cpu_in, 16'h00C3);
        chk("rx_int_high", cpu_int, 1);
        chk("rx_ready_low", dev_rx_ready, 0);
        dev_rx_data = 16'h00C4;
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("rx_int_one_cycle", cpu_int, 0);
        repeat (5) tick();
        chk("rx_ready_wait", dev_rx_ready, 0);
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("gap_ready_0", dev_rx_ready, 0);
        tick();
        chk("gap_ready_1", dev_rx_ready, 0);
        chk("cpu_in_kept", cpu_in, 16'h00C3);
        tick();
        chk("gap_ready_end", dev_rx_ready, 1);
        tick();
        dev_rx_valid = 1'b0;
        chk("rx2_int", cpu_int, 1);
        chk("rx2_cpu_in", cpu_in, 16'h00C4);
        repeat (3) tick();
        finish_read("rx2_done");

        // Randomized concurrent traffic on both paths
        for (int n = 0; n < 800; n++) begin
            cpu_out_wr   = 1'($urandom_range(0, 1));
            cpu_out      = 16'($urandom);
            dev_tx_ready = ($urandom_range(0, 3) != 0);
            cpu_in_rd    = ($urandom_range(0, 3) == 0);
            if (dev_rx_valid && rx_busy && acc_cyc == cyc) begin
                dev_rx_valid = 1'b0;
            end else if (!dev_rx_valid && $urandom_range(0, 2) == 0) begin
                dev_rx_valid = 1'b1;
                dev_rx_data  = 16'($urandom);
            end
            tick();
        end
        cpu_out_wr = 1'b0;
        cpu_in_rd  = 1'b0;
        dev_rx_valid = 1'b0;
        drain("rand_drain");
        finish_read("rand_rx_idle");

        // Unread interrupt: retry behaviour depends on the build
        mon_int_en = 0;
        base = pulse_cnt;
        dev_rx_valid = 1'b1; dev_rx_data = 16'h00C3;
        tick();
        dev_rx_valid = 1'b0;
        repeat (3000) tick();
`ifdef IO_INT_RETRY_EN
        chk("retry_pulses", pulse_cnt - base, 3);
        if (pulse_cnt - base >= 2)
            chk("retry_spacing", pulse_hist[base + 1] - pulse_hist[base], 1025);
`else
        chk("no_retry_pulses", pulse_cnt - base, 1);
`endif
        chk("retry_cpu_in", cpu_in, 16'h00C3);
        finish_read("retry_read");
        mon_int_en = 1;

        chk("final_tx_q", tx_q.size(), 0);
        chk("final_int_q", int_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
